// File: rtl/matrix_addsub_seq.sv
// Sequential N x M signed matrix add/subtract, LANES elements per cycle, optional saturation.
// Operands are captured on an accepted start; res fills group by group and done pulses with the last group.
module matrix_addsub_seq #(
    parameter int N          = 2,
    parameter int M          = 2,
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 1,
    parameter int SATURATE   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         op,
    input  logic [N*M*DATA_WIDTH-1:0]    a,
    input  logic [N*M*DATA_WIDTH-1:0]    b,
    output logic [N*M*DATA_WIDTH-1:0]    res,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
);

    localparam int E  = N * M;
    localparam int G  = E / LANES;
    localparam int W  = E * DATA_WIDTH;
    localparam int GW = LANES * DATA_WIDTH;
    localparam int CW = (G > 1) ? $clog2(G) : 1;

    generate
        if (E % LANES != 0) begin : g_lanes_check
            $error("matrix_addsub_seq: LANES must divide N*M");
        end
    endgenerate

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                 state, state_nxt;
    logic [W-1:0]           a_q, b_q;
    logic                   op_q;
    logic [CW-1:0]          cnt;
    logic                   last;
    logic [W-1:0]           a_grp, b_grp;
    logic [DATA_WIDTH-1:0]  lane_res [LANES];
    logic [LANES-1:0]       lane_ovf;

    assign last = (cnt == CW'(G - 1));
    assign busy = (state == RUN);

    // Shift the current group to the MSB end so each lane reads a fixed slice.
    assign a_grp = a_q << (cnt * GW);
    assign b_grp = b_q << (cnt * GW);

    genvar l;
    generate
        for (l = 0; l < LANES; l++) begin : g_lane
            logic signed [DATA_WIDTH:0] x, y, s;
            logic                       ovf;
            logic [DATA_WIDTH-1:0]      r;

            always_comb begin
                x   = {a_grp[W-1-l*DATA_WIDTH], a_grp[W-1-l*DATA_WIDTH -: DATA_WIDTH]};
                y   = {b_grp[W-1-l*DATA_WIDTH], b_grp[W-1-l*DATA_WIDTH -: DATA_WIDTH]};
                s   = op_q ? (x - y) : (x + y);
                ovf = s[DATA_WIDTH] ^ s[DATA_WIDTH-1];
                r   = s[DATA_WIDTH-1:0];
                if (ovf && (SATURATE != 0)) begin
                    r = s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}};
                end
            end

            assign lane_ovf[l] = ovf;
            assign lane_res[l] = r;
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            cnt      <= '0;
            res      <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == RUN) && last;
            if (state == IDLE) begin
                if (start) begin
                    a_q      <= a;
                    b_q      <= b;
                    op_q     <= op;
                    cnt      <= '0;
                    res      <= '0;
                    overflow <= 1'b0;
                end
            end else begin
                for (int e = 0; e < E; e++) begin
                    if (cnt == CW'(e / LANES))
                        res[(E-1-e)*DATA_WIDTH +: DATA_WIDTH] <= lane_res[e % LANES];
                end
                overflow <= overflow | (|lane_ovf);
                cnt      <= last ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_matrix_addsub_seq.sv
// Bench for matrix_addsub_seq: three instances (saturating, wrapping, two lanes) share stimulus
// and are compared every cycle against an element-level arithmetic model plus literal results.
module tb_matrix_addsub_seq;

    logic        clk = 1'b0;
    logic        rst, start, op;
    logic [63:0] a, b;
    logic [63:0] dres  [3];
    logic        dbusy [3];
    logic        ddone [3];
    logic        dovf  [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    matrix_addsub_seq #(.N(2), .M(2), .DATA_WIDTH(16), .LANES(1), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .res(dres[0]), .busy(dbusy[0]), .done(ddone[0]), .overflow(dovf[0]));
    matrix_addsub_seq #(.N(2), .M(2), .DATA_WIDTH(16), .LANES(1), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .res(dres[1]), .busy(dbusy[1]), .done(ddone[1]), .overflow(dovf[1]));
    matrix_addsub_seq #(.N(2), .M(2), .DATA_WIDTH(16), .LANES(2), .SATURATE(1)) u_lane2 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .res(dres[2]), .busy(dbusy[2]), .done(ddone[2]), .overflow(dovf[2]));

    // Per-instance configuration: groups, lanes, saturate.
    int GG [3] = '{4, 4, 2};
    int LL [3] = '{1, 1, 2};
    int SS [3] = '{1, 0, 1};

    // Reference state for each instance.
    logic [15:0] ma [3][4];
    logic [15:0] mb [3][4];
    logic [15:0] mres [3][4];
    logic        mop [3];
    logic        mrun [3];
    logic        mdone [3];
    logic        movf [3];
    int          mcnt [3];

    function automatic logic [15:0] elem(input logic [63:0] v, input int e);
        return v[(3-e)*16 +: 16];
    endfunction

    function automatic void calc(input logic [15:0] x, input logic [15:0] y, input logic o,
                                 input int sat, output logic [15:0] r, output logic ov);
        int sx, sy, t;
        sx = int'($signed(x));
        sy = int'($signed(y));
        t  = o ? (sx - sy) : (sx + sy);
        ov = (t > 32767) || (t < -32768);
        if (ov && sat != 0) r = (t > 0) ? 16'h7FFF : 16'h8000;
        else                r = t[15:0];
    endfunction

    function automatic logic [63:0] mpack(input int i);
        logic [63:0] v;
        for (int e = 0; e < 4; e++) v[(3-e)*16 +: 16] = mres[i][e];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                mrun[i] = 1'b0; mdone[i] = 1'b0; movf[i] = 1'b0; mcnt[i] = 0; mop[i] = 1'b0;
                for (int e = 0; e < 4; e++) mres[i][e] = 16'h0;
            end else begin
                mdone[i] = 1'b0;
                if (!mrun[i]) begin
                    if (start) begin
                        for (int e = 0; e < 4; e++) begin
                            ma[i][e]   = elem(a, e);
                            mb[i][e]   = elem(b, e);
                            mres[i][e] = 16'h0;
                        end
                        mop[i] = op; movf[i] = 1'b0; mcnt[i] = 0; mrun[i] = 1'b1;
                    end
                end else begin
                    for (int k = 0; k < LL[i]; k++) begin
                        int          e;
                        logic [15:0] r;
                        logic        o;
                        e = mcnt[i] * LL[i] + k;
                        calc(ma[i][e], mb[i][e], mop[i], SS[i], r, o);
                        mres[i][e] = r;
                        if (o) movf[i] = 1'b1;
                    end
                    if (mcnt[i] == GG[i] - 1) begin
                        mrun[i] = 1'b0; mdone[i] = 1'b1;
                    end else begin
                        mcnt[i]++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("cyc res u%0d", i),  dres[i],  mpack(i));
            chk($sformatf("cyc busy u%0d", i), dbusy[i], mrun[i]);
            chk($sformatf("cyc done u%0d", i), ddone[i], mdone[i]);
            chk($sformatf("cyc ovf u%0d", i),  dovf[i],  movf[i]);
        end
    end

    int   ndone [3];
    int   lat   [3];
    logic ovfd  [3];
    int   bcnt;

    // One operation observed over a fixed 12-cycle window.
    task automatic run(input logic [63:0] ta, input logic [63:0] tbv, input logic top,
                       input int restart_k, input int rst_k, input int hold_k);
        a = ta; b = tbv; op = top; start = 1'b1;
        for (int i = 0; i < 3; i++) begin ndone[i] = 0; lat[i] = 0; ovfd[i] = 1'b0; end
        bcnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == hold_k) begin
                start = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = ~op;
            end
            if (restart_k != 0 && k == restart_k) begin
                start = 1'b1; a = {$urandom, $urandom};
            end
            if (restart_k != 0 && k == restart_k + 1) start = 1'b0;
            if (k == rst_k) rst = 1'b1;
            if (rst_k != 0 && k == rst_k + 1) rst = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (ddone[i]) begin
                    ndone[i]++;
                    if (lat[i] == 0) begin lat[i] = k - 1; ovfd[i] = dovf[i]; end
                end
            end
            if (dbusy[0]) bcnt++;
        end
    endtask

    localparam logic [63:0] A1   = 64'h0001_0002_0003_0004;
    localparam logic [63:0] B1   = 64'h000A_0014_001E_0028;
    localparam logic [63:0] R1   = 64'h000B_0016_0021_002C;

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset res",  dres[0],  64'h0);
        chk("reset busy", dbusy[0], 64'h0);
        chk("reset done", ddone[0], 64'h0);
        chk("reset ovf",  dovf[0],  64'h0);
        rst = 1'b0;
        @(negedge clk);

        run(A1, B1, 1'b0, 0, 0, 1);
        chk("add latency g4", lat[0], 64'd4);
        chk("add busy cycles", bcnt, 64'd4);
        chk("add latency lanes2", lat[2], 64'd2);
        chk("add res sat", dres[0], R1);
        chk("add res wrap", dres[1], R1);
        chk("add res lanes2", dres[2], R1);
        chk("add model", mpack(0), R1);
        chk("add ovf", dovf[0], 64'h0);

        run(64'h0005_0000_FFFF_0064, 64'h0007_0000_0001_FFE4, 1'b1, 0, 0, 1);
        chk("sub res", dres[0], 64'hFFFE_0000_FFFE_0080);
        chk("sub ovf", dovf[0], 64'h0);

        run(64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_0001, 1'b0, 0, 0, 1);
        chk("pos ovf sat res", dres[0], 64'h0000_0000_0000_7FFF);
        chk("pos ovf wrap res", dres[1], 64'h0000_0000_0000_8000);
        chk("pos ovf at done sat", ovfd[0], 64'h1);
        chk("pos ovf at done wrap", ovfd[1], 64'h1);

        run(64'h8000_0000_0000_0000, 64'h0001_0000_0000_0000, 1'b1, 0, 0, 1);
        chk("neg ovf sat res", dres[0], 64'h8000_0000_0000_0000);
        chk("neg ovf wrap res", dres[1], 64'h7FFF_0000_0000_0000);
        chk("neg ovf sat flag", dovf[0], 64'h1);
        chk("neg ovf wrap flag", dovf[1], 64'h1);

        run(A1, B1, 1'b0, 2, 0, 1);
        chk("restart done count", ndone[0], 64'd1);
        chk("restart done count lanes2", ndone[2], 64'd1);
        chk("restart res", dres[0], R1);

        run(A1, B1, 1'b0, 0, 2, 1);
        chk("midrst done count", ndone[0], 64'd0);
        chk("midrst done count lanes2", ndone[2], 64'd0);
        chk("midrst res", dres[0], 64'h0);
        chk("midrst busy", dbusy[0], 64'h0);
        run(A1, B1, 1'b0, 0, 0, 1);
        chk("after rst res", dres[0], R1);

        run(A1, B1, 1'b0, 0, 0, 4);
        chk("b2b done count lanes2", ndone[2], 64'd2);
        chk("b2b done count g4", ndone[0], 64'd1);
        chk("b2b res lanes2", dres[2], R1);

        for (int n = 0; n < 30; n++) begin
            run({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 0, 0, 1);
            chk("rand done count", ndone[0], 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/matrix_addsub_seq.md
# matrix_addsub_seq

Sequential, parametrised matrix adder/subtractor for N×M matrices of signed DATA_WIDTH-bit elements. It captures both operand matrices on a start pulse and processes LANES elements per clock. Each element is either added or subtracted, with optional saturation, and overflow is reported. It sits between the matrix operand registers and downstream matrix consumers, and provides a small-area alternative to fully combinational per-element adders.

## Interface
- N, default 2: matrix rows.
- M, default 2: matrix columns.
- DATA_WIDTH, default 16: element width, signed two's complement.
- LANES, default 1: elements processed per cycle.
  - Must divide N*M; elaboration error otherwise.
- SATURATE, default 1: 1 = clamp on overflow; 0 = wrap modulo 2^DATA_WIDTH.
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  1  0 = a+b, 1 = a−b; captured with start.
- a  in  N*M*DATA_WIDTH  first operand matrix.
- b  in  N*M*DATA_WIDTH  second operand matrix.
- res  out  N*M*DATA_WIDTH  result matrix, registered.
- busy  out  1  high while the operation is in progress (RUN).
- done  out  1  one-cycle pulse when res is complete.
- overflow  out  1  sticky; set if any element overflowed in the current operation.

## Operation
- Element layout:
  - Element e = i*M + j (row i, column j) occupies bits [(N*M−e)*DATA_WIDTH−1 : (N*M−e−1)*DATA_WIDTH].
  - Element 0 is therefore at the MSB end. The same layout applies to a, b and res.
- G = N*M/LANES groups. Group g covers elements g*LANES … g*LANES+LANES−1.
- States: IDLE, RUN.
- IDLE:
  - If start=1, capture a, b and op into internal registers.
  - Clear res to 0 and overflow to 0; set group counter to 0; go to RUN.
  - If start=0, hold all outputs.
- RUN, each cycle:
  - Compute the LANES elements of the current group from the captured operands.
  - Write them into res and increment the counter.
  - When the last group (counter = G−1) is written, go to IDLE and assert done for one cycle.
- start while in RUN is ignored; it is neither queued nor able to restart the operation.
- Changes on a, b or op after the capture edge do not affect the result.
- Arithmetic:
  - Form the result at DATA_WIDTH+1 bits (sign-extended operands).
  - An element overflows if the true result is outside [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - On overflow with SATURATE=1: write the max positive value for positive results and the min negative value for negative results.
  - On overflow with SATURATE=0: write the low DATA_WIDTH bits.
  - overflow is set in both modes and stays set until the next accepted start or rst.
- Groups not yet processed read 0 in res until written.

## Timing
- Reset values: res=0, busy=0, done=0, overflow=0, state=IDLE, counter=0.
- rst has priority over every other input in every state. Reset mid-operation abandons the operation, and nothing completes later.
- Edge t0 samples start=1 in IDLE. busy is high from t0 through the edge tG.
- Group g is visible on res after edge t(g+1).
- At edge tG:
  - The final group is written.
  - done rises for exactly one cycle, and busy falls in the same cycle.
- Latency from the start sample to done high is G cycles.
- start=1 during the done cycle is accepted (the state is IDLE), so back-to-back operations sustain one operation per G+1 cycles.
- An overflow on the final group is visible on overflow in the same cycle as done.

## Test plan
- Default parameters, op=0:
  - Stimulus: a = {1,2,3,4}, b = {10,20,30,40}, start pulse.
  - Response: busy high for 4 cycles; done on the 4th cycle after start; res = {11,22,33,44}; overflow = 0.
- op=1:
  - Stimulus: a = {5,0,−1,100}, b = {7,0,1,−28}.
  - Response: res = {0xFFFE, 0x0000, 0xFFFE, 0x0080}; overflow = 0.
- SATURATE=1:
  - Stimulus: 0x7FFF + 0x0001, and 0x8000 − 0x0001.
  - Response: res elements are 0x7FFF and 0x8000; overflow = 1.
- SATURATE=0, same stimulus:
  - Response: res elements are 0x8000 and 0x7FFF; overflow = 1.
- Start during RUN:
  - Stimulus: pulse start again at cycle 2 with different a and b.
  - Response: the original result completes unchanged; exactly one done.
- Reset mid-operation:
  - Stimulus: assert rst for one cycle at cycle 2.
  - Response: res = 0, busy = 0, done never pulses; a subsequent start completes correctly.
- LANES=2:
  - Stimulus: the first scenario's vectors.
  - Response: done 2 cycles after start; identical res. A start held high during the done cycle begins the next operation immediately.
